// File: rtl/btn_pkg.sv
// Shared encodings for the push-button debounce path.
package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      CHK_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      CHK_RELEASE = 2'd3
   } deb_state_t;

   localparam int EV_IDX_W = 3;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, polarity normalization and
// debounce FSM producing a clean level plus one-cycle press/release pulses.
module btn_debounce_chan
   import btn_pkg::*;
#(
   parameter int LOG2DELAY  = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic pin,
   output logic level,
   output logic press,
   output logic rel
);

   localparam logic [LOG2DELAY-1:0] CNT_MAX = '1;

   logic [1:0]           sync;
   logic                 s;
   deb_state_t           state;
   logic [LOG2DELAY-1:0] cnt;

   // Normalized so that 1 = pressed; reset value is therefore "not pressed".
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], pin ^ ACTIVE_LOW};
      end
   end

   assign s = sync[1];

   // NOTE: all state here uses <= so every branch sees pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= RELEASED;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel   <= 1'b0;
      end else begin
         press <= 1'b0;
         rel   <= 1'b0;
         case (state)
            RELEASED: begin
               if (s) begin
                  state <= CHK_PRESS;
                  cnt   <= '0;
               end
            end
            CHK_PRESS: begin
               if (!s) begin
                  state <= RELEASED;
               end else if (cnt == CNT_MAX) begin
                  state <= PRESSED;
                  level <= 1'b1;
                  press <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!s) begin
                  state <= CHK_RELEASE;
                  cnt   <= '0;
               end
            end
            CHK_RELEASE: begin
               if (s) begin
                  state <= PRESSED;
               end else if (cnt == CNT_MAX) begin
                  state <= RELEASED;
                  level <= 1'b0;
                  rel   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule

// File: rtl/btn_debounce.sv
// Debounced push-button bank with per-channel pending bits, a lowest-index
// arbiter and a single-entry valid/ready event register.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int NBTN       = 5,
   parameter int LOG2DELAY  = 16,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [NBTN-1:0]     btn_in,
   output logic [NBTN-1:0]     btn_state,
   output logic [NBTN-1:0]     btn_press,
   output logic [NBTN-1:0]     btn_release,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [EV_IDX_W-1:0] ev_idx,
   output logic                ev_press,
   output logic                overflow
);

   logic [NBTN-1:0]     pend_p, pend_r;
   logic [NBTN-1:0]     eff_p, eff_r;
   logic [NBTN-1:0]     clr_p, clr_r;
   logic                found, load, sel_press;
   logic [EV_IDX_W-1:0] sel_idx;
   int                  sel_i;

   for (genvar g = 0; g < NBTN; g++) begin : g_chan
      btn_debounce_chan #(
         .LOG2DELAY (LOG2DELAY),
         .ACTIVE_LOW(ACTIVE_LOW)
      ) u_chan (
         .clk   (clk),
         .resetn(resetn),
         .pin   (btn_in[g]),
         .level (btn_state[g]),
         .press (btn_press[g]),
         .rel   (btn_release[g])
      );
   end

   // Pulses arriving this cycle are eligible immediately, saving a cycle.
   assign eff_p = pend_p | btn_press;
   assign eff_r = pend_r | btn_release;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      found     = 1'b0;
      sel_i     = 0;
      sel_idx   = '0;
      sel_press = 1'b0;
      for (int i = 0; i < NBTN; i++) begin
         if (!found && (eff_p[i] || eff_r[i])) begin
            found   = 1'b1;
            sel_i   = i;
            sel_idx = EV_IDX_W'(i);
            // With both pending, the older transition is the opposite of the current level.
            sel_press = (eff_p[i] && eff_r[i]) ? !btn_state[i] : eff_p[i];
         end
      end
      load  = found && (!ev_valid || ev_ready);
      clr_p = '0;
      clr_r = '0;
      for (int i = 0; i < NBTN; i++) begin
         clr_p[i] = load && (i == sel_i) && sel_press;
         clr_r[i] = load && (i == sel_i) && !sel_press;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_p   <= '0;
         pend_r   <= '0;
         ev_valid <= 1'b0;
         ev_idx   <= '0;
         ev_press <= 1'b0;
         overflow <= 1'b0;
      end else begin
         // A pulse landing on a bit being drained this edge is kept, not lost.
         pend_p   <= (eff_p & ~clr_p) | (pend_p & btn_press);
         pend_r   <= (eff_r & ~clr_r) | (pend_r & btn_release);
         overflow <= overflow
                   | (|(pend_p & btn_press & ~clr_p))
                   | (|(pend_r & btn_release & ~clr_r));
         if (load) begin
            ev_valid <= 1'b1;
            ev_idx   <= sel_idx;
            ev_press <= sel_press;
         end else if (ev_ready) begin
            ev_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (NBTN=5, LOG2DELAY=2, ACTIVE_LOW=1) with a
// queue scoreboard checked by an independent handshake monitor.
module tb_btn_debounce;

   localparam int NBTN = 5;

   typedef struct packed {
      logic [2:0] idx;
      logic       press;
   } ev_t;

   logic            clk;
   logic            resetn;
   logic [NBTN-1:0] btn_in;
   logic [NBTN-1:0] btn_state, btn_press, btn_release;
   logic            ev_valid, ev_ready, ev_press, overflow;
   logic [2:0]      ev_idx;

   ev_t exp_q[$];
   ev_t mon_ev;
   int  n_checks = 0;
   int  n_pass   = 0;

   btn_debounce #(
      .NBTN      (NBTN),
      .LOG2DELAY (2),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .btn_in     (btn_in),
      .btn_state  (btn_state),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_idx     (ev_idx),
      .ev_press   (ev_press),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int idx, input logic press);
      ev_t e;
      e.idx   = 3'(idx);
      e.press = press;
      exp_q.push_back(e);
   endtask

   // Monitor: a transfer happens at the next rising edge when valid && ready.
   always @(negedge clk) begin
      if (resetn && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL ev_unexpected: got idx=%0d press=%0d, queue empty", ev_idx, ev_press);
         end else begin
            mon_ev = exp_q.pop_front();
            check("ev_data", 32'({ev_idx, ev_press}), 32'({mon_ev.idx, mon_ev.press}));
         end
      end
   end

   initial begin
      resetn   = 1'b0;
      btn_in   = '0;
      ev_ready = 1'b0;
      tick(3);
      check("rst_state", 32'(btn_state), 32'h0);
      check("rst_valid", 32'(ev_valid), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);

      // Buttons held through reset: presses accepted after the window, idx 0..4.
      for (int i = 0; i < NBTN; i++) push(i, 1'b1);
      ev_ready = 1'b1;
      resetn   = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         check("rst_hold_state", 32'(btn_state), 32'h0);
         check("rst_hold_valid", 32'(ev_valid), 32'h0);
      end
      tick(1);
      check("rst_accept_state", 32'(btn_state), 32'h1F);
      check("rst_accept_pulse", 32'(btn_press), 32'h1F);
      tick(1);
      check("rst_first_valid", 32'(ev_valid), 32'h1);
      check("rst_first_idx", 32'(ev_idx), 32'h0);
      tick(6);
      check("rst_no_overflow", 32'(overflow), 32'h0);
      for (int i = 0; i < NBTN; i++) push(i, 1'b0);
      btn_in = '1;
      tick(14);
      check("all_released", 32'(btn_state), 32'h0);

      // Clean press on ch2.
      push(2, 1'b1);
      btn_in[2] = 1'b0;
      tick(6);
      check("ch2_before", 32'(btn_state), 32'h0);
      tick(1);
      check("ch2_state", 32'(btn_state), 32'h04);
      check("ch2_press_pulse", 32'(btn_press), 32'h04);
      tick(1);
      check("ch2_pulse_one_cycle", 32'(btn_press), 32'h0);
      check("ch2_ev_valid", 32'(ev_valid), 32'h1);
      check("ch2_ev", 32'({ev_idx, ev_press}), 32'({3'd2, 1'b1}));
      push(2, 1'b0);
      btn_in[2] = 1'b1;
      tick(7);
      check("ch2_release_pulse", 32'(btn_release), 32'h04);
      tick(6);

      // Bouncy press on ch1: low 3, high 1, then low.
      push(1, 1'b1);
      btn_in[1] = 1'b0;
      tick(3);
      btn_in[1] = 1'b1;
      tick(1);
      btn_in[1] = 1'b0;
      tick(6);
      check("ch1_bounce_wait", 32'(btn_state), 32'h0);
      tick(1);
      check("ch1_bounce_state", 32'(btn_state), 32'h02);
      check("ch1_bounce_pulse", 32'(btn_press), 32'h02);
      tick(4);
      push(1, 1'b0);
      btn_in[1] = 1'b1;
      tick(14);

      // Simultaneous ch4 and ch0 with the consumer stalled.
      push(0, 1'b1);
      push(4, 1'b1);
      ev_ready  = 1'b0;
      btn_in[4] = 1'b0;
      btn_in[0] = 1'b0;
      tick(10);
      check("stall_valid", 32'(ev_valid), 32'h1);
      check("stall_ev", 32'({ev_idx, ev_press}), 32'({3'd0, 1'b1}));
      tick(10);
      check("stall_hold_ev", 32'({ev_idx, ev_press}), 32'({3'd0, 1'b1}));
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      check("stall_next_valid", 32'(ev_valid), 32'h1);
      check("stall_next_ev", 32'({ev_idx, ev_press}), 32'({3'd4, 1'b1}));

      // Overflow on ch3: press, release, press while the register is blocked.
      btn_in[3] = 1'b0;
      tick(7);
      check("ov_press1", 32'(btn_state[3]), 32'h1);
      btn_in[3] = 1'b1;
      tick(7);
      check("ov_release", 32'(btn_state[3]), 32'h0);
      btn_in[3] = 1'b0;
      tick(7);
      check("ov_press2_pulse", 32'(btn_press[3]), 32'h1);
      check("ov_not_yet", 32'(overflow), 32'h0);
      tick(1);
      check("ov_set", 32'(overflow), 32'h1);
      push(3, 1'b0);
      push(3, 1'b1);
      ev_ready = 1'b1;
      tick(5);
      check("ov_drained_valid", 32'(ev_valid), 32'h0);
      push(0, 1'b0);
      push(3, 1'b0);
      push(4, 1'b0);
      btn_in = '1;
      tick(14);
      check("ov_sticky", 32'(overflow), 32'h1);

      // Reset while ch2 is mid-check (CHK_PRESS, counter 2).
      btn_in[2] = 1'b0;
      tick(5);
      resetn = 1'b0;
      #1;
      check("mid_rst_state", 32'(btn_state), 32'h0);
      check("mid_rst_pulses", 32'({btn_press, btn_release}), 32'h0);
      check("mid_rst_ev", 32'({ev_valid, ev_idx, ev_press}), 32'h0);
      check("mid_rst_overflow", 32'(overflow), 32'h0);
      push(2, 1'b1);
      tick(3);
      resetn = 1'b1;
      tick(6);
      check("mid_rst_full_window", 32'(btn_state), 32'h0);
      tick(1);
      check("mid_rst_accept", 32'(btn_state), 32'h04);
      tick(1);
      check("mid_rst_ev", 32'({ev_valid, ev_idx, ev_press}), 32'({1'b1, 3'd2, 1'b1}));
      tick(4);
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
